// File: rtl/tpu_pkg.sv
// +--------------------------------------------------------------------+
// | tpu_pkg : shared widths, INT8 limits and drain state encoding       |
// | Rev 1.0 : initial release                                           |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

package tpu_pkg;

   localparam int ACC_W    = 32;
   localparam int OUT_W    = 8;
   localparam int INT8_MAX = 127;
   localparam int INT8_MIN = -128;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } drain_state_e;

   // Element (r,c) of an n x n matrix starts at this bit of the flat bus.
   function automatic int elem_lsb(input int r, input int c, input int n);
      return (r * n + c) * ACC_W;
   endfunction

endpackage

`default_nettype wire

// File: rtl/tpu_result_drain_if.sv
// +--------------------------------------------------------------------+
// | tpu_result_drain_if : row-per-beat valid/ready result stream        |
// | Rev 1.0 : initial release                                           |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

interface tpu_result_drain_if #(
   parameter int N     = 8,
   parameter int OUT_W = 8
);
   localparam int ROW_W = (N > 1) ? $clog2(N) : 1;

   logic                 out_valid;
   logic                 out_ready;
   logic [N*OUT_W-1:0]   out_data;
   logic [ROW_W-1:0]     out_row;
   logic                 out_last;

   modport master (
      output out_valid, out_data, out_row, out_last,
      input  out_ready
   );

   modport slave (
      input  out_valid, out_data, out_row, out_last,
      output out_ready
   );
endinterface

`default_nettype wire

// File: rtl/tpu_requant_lane.sv
// +--------------------------------------------------------------------+
// | tpu_requant_lane : INT32 -> INT8 round-shift, optional ReLU, clamp  |
// | Rev 1.0 : initial release                                           |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tpu_requant_lane #(
   parameter int ACC_W = tpu_pkg::ACC_W,
   parameter int OUT_W = tpu_pkg::OUT_W
) (
   input  logic [ACC_W-1:0] x,
   input  logic [4:0]       shift,
   input  logic             relu_en,
   output logic [OUT_W-1:0] q
);
   import tpu_pkg::*;

   localparam logic signed [ACC_W:0] c_sat_max = (ACC_W+1)'(INT8_MAX);
   localparam logic signed [ACC_W:0] c_sat_min = (ACC_W+1)'(INT8_MIN);

   logic signed [ACC_W:0] w_ext;
   logic signed [ACC_W:0] w_rnd;
   logic signed [ACC_W:0] w_sum;
   logic signed [ACC_W:0] w_shr;
   logic signed [ACC_W:0] w_v;

   // One extra bit of headroom keeps x + 2^(s-1) from overflowing.
   always_comb begin
      w_ext = $signed({x[ACC_W-1], x});
      w_rnd = '0;
      if (shift != 5'd0) begin
         w_rnd = (ACC_W+1)'(1) << (shift - 5'd1);
      end
      w_sum = w_ext + w_rnd;
      w_shr = w_sum >>> shift;
      w_v   = (relu_en && w_shr[ACC_W]) ? '0 : w_shr;
      if (w_v > c_sat_max) begin
         q = OUT_W'(c_sat_max);
      end else if (w_v < c_sat_min) begin
         q = OUT_W'(c_sat_min);
      end else begin
         q = w_v[OUT_W-1:0];
      end
   end

endmodule

`default_nettype wire

// File: rtl/tpu_result_drain.sv
// +--------------------------------------------------------------------+
// | tpu_result_drain : capture N x N INT32 result, stream INT8 rows     |
// | Rev 1.0 : initial release                                           |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tpu_result_drain #(
   parameter int N     = 8,
   parameter int ACC_W = tpu_pkg::ACC_W,
   parameter int OUT_W = tpu_pkg::OUT_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [N*N*ACC_W-1:0] in_result,
   input  logic [4:0]           shift_amt,
   input  logic                 relu_en,
   tpu_result_drain_if.master   out_if,
   output logic                 busy,
   output logic                 overrun,
   input  logic                 clear_overrun
);
   import tpu_pkg::*;

   localparam int ROW_W    = (N > 1) ? $clog2(N) : 1;
   localparam int ROW_BITS = N * ACC_W;
   localparam logic [ROW_W-1:0] c_last_row = ROW_W'(N - 1);

   drain_state_e           state_q;
   logic [ROW_W-1:0]       row_q;
   logic [N*N*ACC_W-1:0]   buf_q;
   logic [4:0]             shift_q;
   logic                   relu_q;
   logic                   overrun_q;

   logic                   w_xfer;
   logic                   w_last_xfer;
   logic                   w_capture;
   logic                   w_drop;
   logic [ROW_BITS-1:0]    w_row_elems;
   logic [N*OUT_W-1:0]     w_row_quant;

   assign busy        = (state_q == DRAIN);
   assign w_xfer      = busy && out_if.out_ready;
   assign w_last_xfer = w_xfer && (row_q == c_last_row);
   assign w_capture   = in_valid && (!busy || w_last_xfer);
   assign w_drop      = in_valid && busy && !w_last_xfer;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         row_q     <= '0;
         overrun_q <= 1'b0;
      end else begin
         if (w_capture) begin
            state_q <= DRAIN;
            row_q   <= '0;
         end else if (w_last_xfer) begin
            state_q <= IDLE;
            row_q   <= '0;
         end else if (w_xfer) begin
            row_q   <= row_q + 1'b1;
         end
         // A dropped capture outranks a simultaneous clear.
         if (w_drop) begin
            overrun_q <= 1'b1;
         end else if (clear_overrun) begin
            overrun_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_capture) begin
         buf_q   <= in_result;
         shift_q <= shift_amt;
         relu_q  <= relu_en;
      end
   end

   assign w_row_elems = buf_q[elem_lsb(int'(row_q), 0, N) +: ROW_BITS];

   generate
      for (genvar c = 0; c < N; c++) begin : g_lane
         tpu_requant_lane #(
            .ACC_W (ACC_W),
            .OUT_W (OUT_W)
         ) u_lane (
            .x       (w_row_elems[c*ACC_W +: ACC_W]),
            .shift   (shift_q),
            .relu_en (relu_q),
            .q       (w_row_quant[c*OUT_W +: OUT_W])
         );
      end
   endgenerate

   // The buffer is unreset, so data is forced to zero whenever no beat is offered.
   assign out_if.out_valid = busy;
   assign out_if.out_data  = busy ? w_row_quant : '0;
   assign out_if.out_row   = row_q;
   assign out_if.out_last  = busy && (row_q == c_last_row);
   assign overrun          = overrun_q;

endmodule

`default_nettype wire

// File: doc/tpu_result_drain.md
Name: tpu_result_drain

Overview:
- Sits directly downstream of the TPU top level.
- Captures the full N×N INT32 result matrix on the single-cycle output_valid strobe.
- Requantizes each element to INT8: rounding arithmetic right shift, optional ReLU, saturation.
- Streams the matrix out one row per beat over a valid/ready interface, so the host/writeback path never samples the wide result bus directly.

Parameters:
- N, 8, array dimension; matrix is N×N, one output beat per row.
- ACC_W, 32, accumulator element width on the input bus.
- OUT_W, 8, quantized element width on the output bus.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  one-cycle strobe; connects to TPU output_valid.
- in_result  in  N*N*ACC_W  element (r,c) at bits [(r*N+c)*ACC_W +: ACC_W], signed.
- shift_amt  in  5  requant right-shift amount, 0..31, sampled at capture.
- relu_en  in  1  clamp negatives to 0, sampled at capture.
- out_valid  out  1  row beat valid.
- out_ready  in  1  downstream accepts beat.
- out_data  out  N*OUT_W  row r: element c at bits [c*OUT_W +: OUT_W], signed INT8.
- out_row  out  $clog2(N)  index of the row currently presented.
- out_last  out  1  high with out_valid when out_row == N-1.
- busy  out  1  high in DRAIN state.
- overrun  out  1  sticky; a capture was dropped.
- clear_overrun  in  1  clears overrun.

Behaviour:
- Reset values: state=IDLE; out_valid=0; out_row=0; out_last=0; busy=0; overrun=0; out_data=0. The capture buffer is not reset.
- Reset mid-drain aborts the drain. The partial matrix is discarded, and out_valid is 0 in the cycle after rst is sampled.
- States: IDLE, DRAIN.
- IDLE with in_valid=1 → capture:
  - latch in_result, shift_amt and relu_en;
  - row counter ← 0; go to DRAIN.
  - out_valid rises the cycle after in_valid (latency 1).
- DRAIN: out_valid=1 and busy=1.
  - Transfer occurs when out_valid && out_ready. On transfer, the row counter increments.
  - When the transfer is row N-1: if in_valid is high in the same cycle, recapture and stay in DRAIN with row 0 (back-to-back, no bubble); otherwise go to IDLE.
- in_valid in DRAIN other than on the final transfer: the capture is dropped, overrun ← 1, and the current drain is unaffected.
- overrun priority: the set condition wins over a simultaneous clear_overrun.
- Stability: out_data, out_row and out_last are held stable while out_valid && !out_ready.
- Requant, per element, using the latched shift s:
  - s=0 → v = x.
  - s>0 → v = (x + 2^(s-1)) >>> s, computed in ACC_W+1 signed bits so no intermediate overflow occurs (round half up toward +inf).
  - relu_en && v<0 → v = 0.
  - saturate: v>127 → 127; v<-128 → -128; else low OUT_W bits.
- out_data may be combinational from the buffer and row counter, or registered. Either way, the latency above and the stability rule are mandatory.
- With N a power of two, the row counter wraps naturally. No beat is ever emitted with row ≥ N.

Decomposition:
- Shared package tpu_pkg:
  - ACC_W=32, OUT_W=8, INT8_MAX=127, INT8_MIN=-128;
  - drain state encoding (IDLE=0, DRAIN=1);
  - the element-index bit-slice convention.
- One sub-module, tpu_requant_lane: purely combinational, one element. Inputs x[ACC_W], shift[5], relu_en; output q[OUT_W].
- N instances cover one row; the row is selected by a mux on the buffer.

Test Plan (N=4 unless stated):
- Identity drain: result(r,c) = r*4+c, shift=0, relu=0, out_ready=1 → 4 beats on consecutive cycles starting 1 cycle after in_valid; row 2 out_data bytes = 8,9,10,11; out_last only on beat 4; busy falls after beat 4.
- Rounding/saturation: elements 5, 6, -6, 1000, -1000, with shift=2 → 1, 2, -1, 127, -128. Elements 1000 and -1000 with shift=3 → 125, -125. With relu=1, -6 → 0 and -1000 → 0.
- Backpressure: out_ready toggles 1,0,0,1,… → no beat lost or duplicated; out_data and out_row held while stalled; 4 beats total, rows 0..3 in order.
- Back-to-back: second in_valid in the same cycle as the row-3 transfer → the next cycle presents row 0 of the new matrix; overrun stays 0.
- Overrun: in_valid during row 1 of a drain → the drain completes with the original data; overrun=1 and stays set. clear_overrun → 0. Set and clear in the same cycle → 1.
- Reset mid-drain: rst asserted after row 1 transfer → next cycle out_valid=0, busy=0, out_row=0, overrun=0. A subsequent capture drains normally from row 0.
